// File: rtl/vecmac_pkg.sv
// ----------------------------------------------------------------------------
// vecmac_pkg
//   Shared widths and types for the dot-product datapath (multiply stage,
//   adder tree and accumulator).
//
//   Contents
//     W_OP / W_PROD / W_PSUM / W_ACC : operand, product, partial-sum and
//                                      accumulator widths
//     LANES                          : operand pairs per beat
//     BEATS                          : beats per vector
//     op_t, prod_t, psum_t           : matching logic vector types
// ----------------------------------------------------------------------------
package vecmac_pkg;

  localparam int W_OP   = 8;
  localparam int W_PROD = 2 * W_OP;       // 16
  localparam int W_PSUM = W_PROD + 2;     // 18: 4 products of 16 bits
  localparam int W_ACC  = 26;
  localparam int LANES  = 4;
  localparam int BEATS  = 250;

  typedef logic [W_OP-1:0]   op_t;
  typedef logic [W_PROD-1:0] prod_t;
  typedef logic [W_PSUM-1:0] psum_t;

endpackage : vecmac_pkg

// File: rtl/vecmac_mul8.sv
// ----------------------------------------------------------------------------
// vecmac_mul8
//   Unsigned 8x8 multiplier in LUT fabric with a registered product.
//   This register is pipeline stage S1 of one lane of vecmul_adder_tree.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous reset, active-high; clears the product register
//     en   : load a*b into the product register
//     a, b : unsigned operands
//     p    : registered product
// ----------------------------------------------------------------------------
module vecmac_mul8
  import vecmac_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  op_t   a,
  input  op_t   b,
  output prod_t p
);

  // Keep the multiplier out of DSP blocks, like the accumulator it feeds.
  (* use_dsp = "no" *) prod_t p_q;

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
    end else if (en) begin
      p_q <= prod_t'(a) * prod_t'(b);
    end
  end

  assign p = p_q;

endmodule : vecmac_mul8

// File: rtl/vecmul_adder_tree.sv
// ----------------------------------------------------------------------------
// vecmul_adder_tree
//   4-lane unsigned int8 multiply plus a 2-level adder tree. Each valid beat
//   carries 4 operand pairs and produces one partial sum (the dot product of
//   the beat) three registered stages later. 1 beat/clk, no backpressure.
//
//     S1  p_i         = a_i * b_i       (vecmac_mul8, 16 b)
//     S2  s0, s1      = p0+p1, p2+p3    (17 b)
//     S3  partial_sum = s0 + s1         (18 b)
//
//   Ports
//     clk         : rising-edge clock
//     rst         : synchronous reset, active-high (priority over flush)
//     flush       : synchronous pipeline clear, drops all beats in flight and
//                   the beat presented in the same cycle (priority over in_valid)
//     in_valid    : beat present on in_a / in_b
//     in_a, in_b  : lane i = bits [W_OP*i +: W_OP]
//     out_valid   : partial_sum is valid
//     partial_sum : sum over lanes of a_i*b_i; holds while out_valid = 0
//     out_last    : only with VMAT_BEAT_CNT_EN; marks output beat BEATS-1
//
//   Build option
//     VMAT_BEAT_CNT_EN : adds a beat counter over S3 outputs and the out_last
//                        port. Without it, vector framing is left entirely to
//                        the accumulator.
// ----------------------------------------------------------------------------
module vecmul_adder_tree #(
  parameter int LANES = vecmac_pkg::LANES,
  parameter int W_OP  = vecmac_pkg::W_OP,
  parameter int W_OUT = vecmac_pkg::W_PSUM,
  parameter int BEATS = vecmac_pkg::BEATS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [LANES*W_OP-1:0] in_a,
  input  logic [LANES*W_OP-1:0] in_b,
  output logic                  out_valid,
  output logic [W_OUT-1:0]      partial_sum
`ifdef VMAT_BEAT_CNT_EN
  ,
  output logic                  out_last
`endif
);

  localparam int W_PROD = 2 * W_OP;
  localparam int W_SUM  = W_PROD + 1;

  // The tree below is hard-wired for 4 lanes on the package operand type.
  if (LANES != 4) begin : g_bad_lanes
    $error("vecmul_adder_tree: LANES must be 4");
  end
  if (W_OP != vecmac_pkg::W_OP) begin : g_bad_w_op
    $error("vecmul_adder_tree: W_OP must match vecmac_pkg::W_OP");
  end
  if (W_OUT < 2 * W_OP + 2) begin : g_bad_w_out
    $error("vecmul_adder_tree: W_OUT must be >= 2*W_OP+2");
  end
  if (BEATS < 2) begin : g_bad_beats
    $error("vecmul_adder_tree: BEATS must be >= 2");
  end

  // --------------------------------------------------------------------------
  // Valid chain. flush kills every stage on the same edge, including the
  // beat being presented.
  // --------------------------------------------------------------------------
  logic v1, v2;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  // --------------------------------------------------------------------------
  // S1: per-lane registered multipliers. Loading only real beats keeps the
  // downstream data stable when idle.
  // --------------------------------------------------------------------------
  logic              s1_en;
  logic [W_PROD-1:0] prod [LANES];

  assign s1_en = in_valid && !flush;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vecmac_mul8 u_mul (
      .clk (clk),
      .rst (rst),
      .en  (s1_en),
      .a   (in_a[i*W_OP +: W_OP]),
      .b   (in_b[i*W_OP +: W_OP]),
      .p   (prod[i])
    );
  end

  // --------------------------------------------------------------------------
  // S2 / S3: zero-extended adds; 4*255*255 fits in 18 bits, so no carry-out
  // or saturation handling. Data registers are gated by their stage valid
  // and by flush, so partial_sum holds its last value whenever out_valid = 0.
  // --------------------------------------------------------------------------
  logic [W_SUM-1:0] s0, s1;

  // NOTE: data registers are reset as well as valid bits, so partial_sum
  // reads 0 after reset rather than a stale sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
    end else if (v1 && !flush) begin
      s0 <= W_SUM'(prod[0]) + W_SUM'(prod[1]);
      s1 <= W_SUM'(prod[2]) + W_SUM'(prod[3]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      partial_sum <= '0;
    end else if (v2 && !flush) begin
      partial_sum <= W_OUT'(s0) + W_OUT'(s1);
    end
  end

`ifdef VMAT_BEAT_CNT_EN
  // --------------------------------------------------------------------------
  // Beat counter over S3 outputs. beat_cnt is the index of the beat now
  // entering S3; out_last is registered alongside out_valid.
  // --------------------------------------------------------------------------
  localparam int W_CNT = $clog2(BEATS);
  localparam logic [W_CNT-1:0] LAST_BEAT = W_CNT'(BEATS - 1);

  logic [W_CNT-1:0] beat_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      beat_cnt <= '0;
      out_last <= 1'b0;
    end else if (v2) begin
      out_last <= (beat_cnt == LAST_BEAT);
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end else begin
      out_last <= 1'b0;
    end
  end
`endif

endmodule : vecmul_adder_tree
